// File: rtl/tictactoe_pkg.sv
// tictactoe_pkg
//   Shared types and elaboration-time helpers for the N x N, K-in-a-row game.
//   - state_t   : game FSM states
//   - num_runs  : number of K-long runs (rows, columns, diagonals, anti-diagonals)
//   - run_mask  : cell mask of one run; cell (r,c) is bit N*N-1-(r*N+c)
//   - popcount  : number of set bits in a (zero-extended) mask
package tictactoe_pkg;

    typedef enum logic [2:0] {
        P1_TURN,
        P2_TURN,
        P1_WIN,
        P2_WIN,
        DRAW
    } state_t;

    function automatic int num_runs(input int n, input int k);
        return 2 * n * (n - k + 1) + 2 * (n - k + 1) * (n - k + 1);
    endfunction

    // Runs are enumerated direction by direction: horizontal, vertical,
    // diagonal (down-right), anti-diagonal (down-left).
    function automatic logic [63:0] run_mask(input int n, input int k, input int idx);
        logic [63:0] m;
        int          cnt;
        int          dr;
        int          dc;
        int          er;
        int          ec;
        m   = '0;
        cnt = 0;
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            for (int r = 0; r < n; r++) begin
                for (int c = 0; c < n; c++) begin
                    er = r + (k - 1) * dr;
                    ec = c + (k - 1) * dc;
                    if (er >= 0 && er < n && ec >= 0 && ec < n) begin
                        if (cnt == idx) begin
                            for (int j = 0; j < k; j++)
                                m[n * n - 1 - ((r + j * dr) * n + (c + j * dc))] = 1'b1;
                        end
                        cnt++;
                    end
                end
            end
        end
        return m;
    endfunction

    function automatic int popcount(input logic [63:0] v);
        int s;
        s = 0;
        for (int i = 0; i < 64; i++)
            s += int'(v[i]);
        return s;
    endfunction

endpackage

// File: rtl/tictactoe_line_check.sv
// tictactoe_line_check
//   Combinational win detector for one player's board.
//   Ports:
//     i_board [N*N-1:0] : occupancy mask of one player
//     o_win             : high when any K-long run is fully occupied
module tictactoe_line_check
    import tictactoe_pkg::*;
#(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic [N*N-1:0] i_board,
    output logic           o_win
);

    localparam int NC = N * N;
    localparam int NR = num_runs(N, K);

    logic [NR-1:0] w_hit;

    for (genvar g = 0; g < NR; g++) begin : g_run
        localparam logic [63:0] MASK_FULL = run_mask(N, K, g);
        localparam logic [NC-1:0] MASK = MASK_FULL[NC-1:0];
        // every cell of the run is set <=> no run cell is clear
        assign w_hit[g] = &(i_board | ~MASK);
    end

    assign o_win = |w_hit;

endmodule

// File: rtl/tictactoe_nxn.sv
// tictactoe_nxn
//   N x N, K-in-a-row two-player game engine with edge-detected switch input,
//   turn/occupancy enforcement, win/draw detection and alternating start player.
//   Optional macro TTT_BLINK_EN: win/draw LEDs blink with a half-period of
//   2^BLINK_LOG2 cycles instead of being steady.
//   Ports:
//     clk, rst            : clock, async active-high reset
//     rst1, rst2          : synchronous new-game requests
//     player1, player2    : cumulative switch masks (MSB = top-left cell)
//     p1out, p2out        : registered board occupancy
//     turn                : 0 = player 1 to move, 1 = player 2 to move
//     p1win, p2win, done  : registered game result flags
//     led1win, led2win    : win LEDs (both lit in a draw)
//     illegal             : one-cycle pulse on a rejected press
//     reset               : one-cycle pulse on a restart
module tictactoe_nxn
    import tictactoe_pkg::*;
#(
    parameter int N          = 3,
    parameter int K          = 3,
    parameter int BLINK_LOG2 = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rst1,
    input  logic           rst2,
    input  logic [N*N-1:0] player1,
    input  logic [N*N-1:0] player2,
    output logic [N*N-1:0] p1out,
    output logic [N*N-1:0] p2out,
    output logic           turn,
    output logic           p1win,
    output logic           p2win,
    output logic           done,
    output logic           led1win,
    output logic           led2win,
    output logic           illegal,
    output logic           reset
);

    localparam int NC = N * N;

    state_t          r_state, w_state_n;
    logic [NC-1:0]   r_p1_q, r_p2_q;
    logic [NC-1:0]   r_p1out, r_p2out, w_p1out_n, w_p2out_n;
    logic            r_turn, w_turn_n;
    logic            r_start, w_start_n;
    logic            r_p1win, r_p2win, r_done, r_illegal, r_reset;
    logic            w_illegal_n, w_reset_n;

    logic [NC-1:0]   w_new1, w_new2, w_mover_new, w_off_new, w_occ;
    logic            w_win1, w_win2, w_full, w_restart;

    assign w_new1      = player1 & ~r_p1_q;
    assign w_new2      = player2 & ~r_p2_q;
    assign w_mover_new = r_turn ? w_new2 : w_new1;
    assign w_off_new   = r_turn ? w_new1 : w_new2;
    assign w_occ       = r_p1out | r_p2out;
    assign w_full      = &w_occ;
    assign w_restart   = rst1 | rst2;

    tictactoe_line_check #(.N(N), .K(K)) u_chk1 (.i_board(r_p1out), .o_win(w_win1));
    tictactoe_line_check #(.N(N), .K(K)) u_chk2 (.i_board(r_p2out), .o_win(w_win2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= P1_TURN;
            r_p1_q    <= '0;
            r_p2_q    <= '0;
            r_p1out   <= '0;
            r_p2out   <= '0;
            r_turn    <= 1'b0;
            r_start   <= 1'b0;
            r_p1win   <= 1'b0;
            r_p2win   <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
            r_reset   <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_p1_q    <= player1;
            r_p2_q    <= player2;
            r_p1out   <= w_p1out_n;
            r_p2out   <= w_p2out_n;
            r_turn    <= w_turn_n;
            r_start   <= w_start_n;
            r_p1win   <= (w_state_n == P1_WIN);
            r_p2win   <= (w_state_n == P2_WIN);
            r_done    <= (w_state_n == P1_WIN) || (w_state_n == P2_WIN) || (w_state_n == DRAW);
            r_illegal <= w_illegal_n;
            r_reset   <= w_reset_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_p1out_n   = r_p1out;
        w_p2out_n   = r_p2out;
        w_turn_n    = r_turn;
        w_start_n   = r_start;
        w_illegal_n = 1'b0;
        w_reset_n   = 1'b0;
        if (w_restart) begin
            w_p1out_n = '0;
            w_p2out_n = '0;
            w_start_n = ~r_start;
            w_turn_n  = ~r_start;
            w_state_n = r_start ? P1_TURN : P2_TURN;
            w_reset_n = 1'b1;
        end else begin
            case (r_state)
                P1_TURN, P2_TURN: begin
                    // The result of the last move is resolved before any new
                    // press, so the move that completes a line is the final one.
                    if (w_win1 || w_win2 || w_full) begin
                        w_state_n   = w_win1 ? P1_WIN : w_win2 ? P2_WIN : DRAW;
                        w_illegal_n = |{w_new1, w_new2};
                    end else begin
                        if (w_mover_new != '0) begin
                            if (popcount(64'(w_mover_new)) == 1 && (w_mover_new & w_occ) == '0) begin
                                if (r_turn) w_p2out_n = r_p2out | w_mover_new;
                                else        w_p1out_n = r_p1out | w_mover_new;
                                w_turn_n  = ~r_turn;
                                w_state_n = r_turn ? P1_TURN : P2_TURN;
                            end else begin
                                w_illegal_n = 1'b1;
                            end
                        end
                        if (w_off_new != '0)
                            w_illegal_n = 1'b1;
                    end
                end
                default: w_illegal_n = |{w_new1, w_new2};
            endcase
        end
    end

    assign p1out   = r_p1out;
    assign p2out   = r_p2out;
    assign turn    = r_turn;
    assign p1win   = r_p1win;
    assign p2win   = r_p2win;
    assign done    = r_done;
    assign illegal = r_illegal;
    assign reset   = r_reset;

    logic w_draw;
    assign w_draw = r_done & ~r_p1win & ~r_p2win;

`ifdef TTT_BLINK_EN
    logic [BLINK_LOG2-1:0] r_blink_cnt;
    logic                  r_blink_on;

    // The counter is held at zero until the game ends so the first lit
    // half-period after a result is a full 2^BLINK_LOG2 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else if (w_restart || !r_done) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (&r_blink_cnt)
                r_blink_on <= ~r_blink_on;
        end
    end

    assign led1win = r_blink_on & (r_p1win | w_draw);
    assign led2win = r_blink_on & (r_p2win | w_draw);
`else
    logic w_unused_blink;
    assign w_unused_blink = (BLINK_LOG2 > 0);
    assign led1win = r_p1win | w_draw;
    assign led2win = r_p2win | w_draw;
`endif

endmodule
